alu_share_arbiter: RTL

Two-port arbiter and sequencer that shares one external integer ALU between two requesters, e.g. the execute stage (port 0) and the branch/compare unit (port 1). It arbitrates valid/ready requests round-robin, registers the winning operands, drives the ALU, and captures the result into a per-port one-entry response buffer drained by a valid/ready handshake. The ALU is purely combinational and sits beside this block; this block owns its inputs.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_share_arbiter_rr_arb2.sv | 18 +
 rtl/alu_share_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the shared-ALU arbiter: op codes, compare-op classification, FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SLL  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        SLT  = 4'd8,
        SLTU = 4'd9,
        BEQ  = 4'd10,
        BNE  = 4'd11,
        BLT  = 4'd12,
        BGE  = 4'd13,
        BLTU = 4'd14,
        BGEU = 4'd15
    } alu_op_e;

    localparam logic [3:0] CMP_FIRST = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    // Compare ops report through alu_zero; everything below them is arithmetic/logic.
    function automatic logic is_cmp_op(input logic [3:0] op);
        return op >= CMP_FIRST;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone eligible port wins, a tie goes to the port that did not win last.
module rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |eligible;
        case (eligible)
            2'b11:   grant = ~last_grant;
            2'b10:   grant = 1'b1;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters: round-robin grant, one execute
// cycle, and a one-entry response buffer per port drained by valid/ready.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req_op0,
    input  logic [OP_W-1:0]   req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_b1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_result0,
    output logic [DATA_W-1:0] rsp_result1,
    output logic              rsp_flag0,
    output logic              rsp_flag1,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [OP_W-1:0]   alu_ctrl,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              busy
);

    // state | meaning
    // IDLE  | waiting for an eligible request; ALU inputs hold the last op
    // EXEC  | registered op on the ALU; result lands in the grantee's buffer at cycle end

    state_e            state;
    logic              last_grant;
    logic              gnt_id;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    logic [1:0]        eligible;
    logic              arb_grant;
    logic              arb_valid;
    logic              accept;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic              exec_cmp;

    // A port with an undrained response may not start another op.
    assign eligible = req_valid & ~rsp_valid;

    rr_arb2 u_arb (
        .eligible    (eligible),
        .last_grant  (last_grant),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    assign accept    = rst_n && (state == ST_IDLE) && arb_valid;
    assign req_ready = accept ? (arb_grant ? 2'b10 : 2'b01) : 2'b00;

    assign sel_op = arb_grant ? req_op1 : req_op0;
    assign sel_a  = arb_grant ? req_a1  : req_a0;
    assign sel_b  = arb_grant ? req_b1  : req_b0;

    assign alu_in1  = a_q;
    assign alu_in2  = b_q;
    assign alu_ctrl = op_q;
    assign busy     = (state == ST_EXEC);
    assign exec_cmp = is_cmp_op(op_q[3:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            gnt_id      <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid   <= 2'b00;
            rsp_result0 <= '0;
            rsp_result1 <= '0;
            rsp_flag0   <= 1'b0;
            rsp_flag1   <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        op_q       <= sel_op;
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        gnt_id     <= arb_grant;
                        last_grant <= arb_grant;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Only the ALU output relevant to the op class is sampled.
                    rsp_valid[gnt_id] <= 1'b1;
                    if (gnt_id) begin
                        rsp_result1 <= exec_cmp ? '0 : alu_out;
                        rsp_flag1   <= exec_cmp & alu_zero;
                    end else begin
                        rsp_result0 <= exec_cmp ? '0 : alu_out;
                        rsp_flag0   <= exec_cmp & alu_zero;
                    end
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
